// File: rtl/imem_fetch_unit.sv
// Instruction memory with a registered valid/ready fetch port, PC fault detection and a
// byte-serial program-load port. Fetches are served only while no load is in progress.
module imem_fetch_unit #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     DEPTH     = 3000,
    parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(32'h8000_0000),
    parameter string           INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic [WIDTH-1:0] fetch_addr,
    output logic             fetch_ready,
    output logic             rsp_valid,
    output logic [31:0]      instr,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       func_3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       func_7,
    output logic             func_7_sig,
    output logic             fault_misalign,
    output logic             fault_range,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    input  logic             load_done,
    output logic [15:0]      load_words,
    output logic             load_overflow
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {StIdle, StLoad} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   asm_q, asm_d;
    logic          ovf_q, ovf_d;
    logic          rsp_valid_q;
    logic [31:0]   instr_q;
    logic          mis_q, rng_q;

    logic [31:0]   mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [31:0]   asm_n;
    logic [2:0]    cnt_n;
    logic          wr_req;

    logic             accept;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] idx;
    logic             f_mis, f_rng;
    logic [31:0]      rd_data;

    // Load path: bytes fill the assembler; a full word or a flush on load_done writes it.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_wdata = asm_q;
        asm_n     = asm_q;
        cnt_n     = {1'b0, cnt_q};
        wr_req    = 1'b0;
        if (load_start) begin
            state_d = StLoad;
            ptr_d   = '0;
            cnt_d   = '0;
            asm_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == StLoad) begin
            if (load_valid) begin
                asm_n[8*cnt_q +: 8] = load_byte;
                cnt_n               = cnt_n + 3'd1;
            end
            wr_req    = (cnt_n == 3'd4) || (load_done && (cnt_n != 3'd0));
            mem_wdata = asm_n;
            if (wr_req) begin
                cnt_d = '0;
                asm_d = '0;
                if (ptr_q == PW'(DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + PW'(1);
                end
            end else begin
                cnt_d = cnt_n[1:0];
                asm_d = asm_n;
            end
            if (load_done) begin
                state_d = StIdle;
                cnt_d   = '0;
                asm_d   = '0;
            end
        end
    end

    assign mem_waddr = ptr_q[AW-1:0];

    // Fetch path: index arithmetic wraps modulo 2^WIDTH, so PCs below BASE_ADDR need the
    // explicit compare as well.
    always_comb begin
        accept  = fetch_req && (state_q == StIdle);
        offset  = fetch_addr - BASE_ADDR;
        idx     = offset >> 2;
        f_mis   = (fetch_addr[1:0] != 2'b00);
        f_rng   = (idx >= WIDTH'(DEPTH)) || (fetch_addr < BASE_ADDR);
        rd_data = mem[idx[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            instr_q     <= NOP;
            mis_q       <= 1'b0;
            rng_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= accept;
            if (accept) begin
                instr_q <= (f_mis || f_rng) ? NOP : rd_data;
                mis_q   <= f_mis;
                rng_q   <= f_rng;
            end
        end
    end

    // Contents survive reset so an interrupted load keeps its completed words.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_ready    = (state_q == StIdle);
    assign rsp_valid      = rsp_valid_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[6:0];
    assign rd             = instr_q[11:7];
    assign func_3         = instr_q[14:12];
    assign rs1            = instr_q[19:15];
    assign rs2            = instr_q[24:20];
    assign func_7         = instr_q[31:25];
    assign func_7_sig     = instr_q[30];
    assign fault_misalign = mis_q;
    assign fault_range    = rng_q;
    assign load_words     = 16'(ptr_q);
    assign load_overflow  = ovf_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with DEPTH = 4: reset, load/fetch, faults, overflow,
// fetch/load collisions and reset in the middle of a load.
module tb_imem_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_ready, rsp_valid;
    logic [31:0] instr;
    logic [6:0]  opcode, func_7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func_3;
    logic        func_7_sig, fault_misalign, fault_range;
    logic        load_start = 1'b0, load_valid = 1'b0, load_done = 1'b0;
    logic [7:0]  load_byte = 8'h0;
    logic [15:0] load_words;
    logic        load_overflow;

    int tests = 0;
    int fails = 0;

    imem_fetch_unit #(
        .WIDTH    (32),
        .DEPTH    (4),
        .BASE_ADDR(32'h8000_0000),
        .INIT_FILE("")
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_ready   (fetch_ready),
        .rsp_valid     (rsp_valid),
        .instr         (instr),
        .opcode        (opcode),
        .rd            (rd),
        .func_3        (func_3),
        .rs1           (rs1),
        .rs2           (rs2),
        .func_7        (func_7),
        .func_7_sig    (func_7_sig),
        .fault_misalign(fault_misalign),
        .fault_range   (fault_range),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_byte     (load_byte),
        .load_done     (load_done),
        .load_words    (load_words),
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        load_valid = 1'b1;
        load_byte  = b;
        load_done  = done;
        cyc();
        load_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        cyc();
        fetch_req  = 1'b0;
    endtask

    initial begin
        // Asynchronous reset asserted mid-cycle
        #12;
        rst = 1'b1;
        #1;
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'h13);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_words", 32'(load_words), 32'd0);
        chk("rst_ovf", 32'(load_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // Load two words; last byte arrives together with load_done
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("load_ready_low", 32'(fetch_ready), 32'd0);
        send_byte(8'hB3, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h06, 1'b1);
        chk("load_words_2", 32'(load_words), 32'd2);
        chk("load_ready_high", 32'(fetch_ready), 32'd1);

        fetch(32'h8000_0000);
        chk("f0_valid", 32'(rsp_valid), 32'd1);
        chk("f0_instr", instr, 32'h0000_05B3);
        chk("f0_opcode", 32'(opcode), 32'h33);
        chk("f0_rd", 32'(rd), 32'd11);
        chk("f0_faults", {30'd0, fault_misalign, fault_range}, 32'd0);
        cyc();
        chk("hold_valid", 32'(rsp_valid), 32'd0);
        chk("hold_instr", instr, 32'h0000_05B3);

        // Back-to-back fetches, second one misaligned
        fetch_req  = 1'b1;
        fetch_addr = 32'h8000_0004;
        cyc();
        chk("f1_instr", instr, 32'h0000_0613);
        chk("f1_rd", 32'(rd), 32'd12);
        chk("f1_opcode", 32'(opcode), 32'h13);
        fetch_addr = 32'h8000_0002;
        cyc();
        fetch_req = 1'b0;
        chk("mis_valid", 32'(rsp_valid), 32'd1);
        chk("mis_flag", 32'(fault_misalign), 32'd1);
        chk("mis_range", 32'(fault_range), 32'd0);
        chk("mis_instr", instr, 32'h0000_0013);

        fetch(32'h7FFF_FFFC);
        chk("below_range", 32'(fault_range), 32'd1);
        chk("below_mis", 32'(fault_misalign), 32'd0);
        chk("below_instr", instr, 32'h0000_0013);
        fetch(32'h8000_0010);
        chk("above_range", 32'(fault_range), 32'd1);
        chk("above_instr", instr, 32'h0000_0013);
        fetch(32'h8000_000C);
        chk("last_in_range", 32'(fault_range), 32'd0);

        // Overflow: 20 bytes into 4 words
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i), 1'b0);
        chk("ovf_words", 32'(load_words), 32'd4);
        chk("ovf_flag", 32'(load_overflow), 32'd1);
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;
        chk("ovf_sticky", 32'(load_overflow), 32'd1);
        fetch(32'h8000_0000);
        chk("ovf_word0", instr, 32'h1312_1110);
        fetch(32'h8000_000C);
        chk("ovf_word3", instr, 32'h1F1E_1D1C);
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("restart_ovf", 32'(load_overflow), 32'd0);
        chk("restart_words", 32'(load_words), 32'd0);
        load_done = 1'b1;
        cyc();
        load_done = 1'b0;

        // Fetch collides with load_start: old contents served, then LOAD
        fetch_req  = 1'b1;
        fetch_addr = 32'h8000_0004;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        fetch_addr = 32'h8000_0000;
        chk("coll_valid", 32'(rsp_valid), 32'd1);
        chk("coll_instr", instr, 32'h1716_1514);
        chk("coll_ready", 32'(fetch_ready), 32'd0);
        send_byte(8'hAA, 1'b0);
        chk("coll_no_accept", 32'(rsp_valid), 32'd0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        chk("coll_rsp_low", 32'(rsp_valid), 32'd0);
        chk("coll_ready_back", 32'(fetch_ready), 32'd1);
        chk("coll_words", 32'(load_words), 32'd1);
        cyc();
        fetch_req = 1'b0;
        chk("dec_instr", instr, 32'hDDCC_BBAA);
        chk("dec_opcode", 32'(opcode), 32'h2A);
        chk("dec_rd", 32'(rd), 32'h17);
        chk("dec_f3", 32'(func_3), 32'd3);
        chk("dec_rs1", 32'(rs1), 32'h19);
        chk("dec_rs2", 32'(rs2), 32'h1C);
        chk("dec_f7", 32'(func_7), 32'h6E);
        chk("dec_f7sig", 32'(func_7_sig), 32'd1);

        // Reset in the middle of a load
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_ready", 32'(fetch_ready), 32'd1);
        chk("mrst_words", 32'(load_words), 32'd0);
        chk("mrst_instr", instr, 32'h0000_0013);
        #2;
        rst = 1'b0;
        cyc();
        send_byte(8'h77, 1'b0);
        chk("idle_byte_ignored", 32'(load_words), 32'd0);
        fetch(32'h8000_0000);
        chk("mrst_word0", instr, 32'h0403_0201);
        fetch(32'h8000_0004);
        chk("mrst_word1", instr, 32'h1716_1514);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
